mure_retire_fifo: RTL and testbench
===================================

Name: mure_retire_fifo

Overview:
- Upstream capture stage for multiple_retire.
- Samples the CPU commit ports each cycle (up to NRET retirements per cycle, plus trap information) and compacts the valid lanes in order into a circular buffer.
- Presents buffered entries one per cycle on a valid/ready interface, so the downstream stage sees a single ordered instruction stream.
- The CPU is never stalled. Overflow is detected, counted and flagged instead.

Parameters:
NRET, 2, commit lanes per cycle (>=1)
DEPTH, 8, buffer entries; power of two, >= 2*NRET
XLEN, 64, address/tval width
INST_LEN, 32, instruction word width
CAUSE_LEN, 5, trap cause width
PRIV_LEN, 2, privilege level width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
valids_i  in  NRET  per-lane retire valid
pcs_i  in  NRET*XLEN  per-lane PC, lane k at [k*XLEN +: XLEN]
insts_i  in  NRET*INST_LEN  per-lane instruction word
compressed_i  in  NRET  per-lane compressed flag
exception_i  in  1  trap this cycle (exception or interrupt)
interrupt_i  in  1  trap is an interrupt (qualified by exception_i)
cause_i  in  CAUSE_LEN  trap cause
tval_i  in  XLEN  trap value
trap_pc_i  in  XLEN  PC of trapping instruction (used when no lane valid)
priv_lvl_i  in  PRIV_LEN  current privilege
valid_o  out  1  head entry valid
ready_i  in  1  downstream accepts head
iretired_o  out  1  head entry is a retired instruction
exception_o  out  1  head entry carries exception
interrupt_o  out  1  head entry carries interrupt
pc_o  out  XLEN  head PC
inst_data_o  out  INST_LEN  head instruction
compressed_o  out  1  head compressed flag
cause_o  out  CAUSE_LEN  head cause (0 if no trap)
tval_o  out  XLEN  head tval (0 if no trap)
priv_o  out  PRIV_LEN  head privilege
count_o  out  $clog2(DEPTH+1)  occupied entries
overflow_o  out  1  sticky: a push was dropped since reset
drop_cnt_o  out  16  dropped entries, saturating at 16'hFFFF

Behaviour:
- Reset (async, rst_i=1): pointers=0, count=0, overflow_o=0, drop_cnt_o=0, valid_o=0. All payload outputs read 0 while empty.
- Push set per cycle, with no trap (exception_i=0):
  - one entry per set bit of valids_i, in ascending lane order.
  - Lane gaps are allowed; valids_i=2'b10 pushes lane 1 only.
  - iretired=1 on every entry; trap fields 0.
- Trap, exception_i=1 with at least one valid lane:
  - only the lowest valid lane is pushed; higher lanes are discarded (killed by the trap).
  - The pushed entry has iretired=1, exception=~interrupt_i, interrupt=interrupt_i, cause_i, tval_i.
- Trap, exception_i=1 with valids_i=0:
  - one entry is pushed with iretired=0, pc=trap_pc_i, inst=0, trap fields as above.
- priv_lvl_i is captured into every entry pushed that cycle.
- Pop: when valid_o && ready_i at a rising edge, the head advances by one.
  - valid_o = (count != 0).
  - Outputs are a combinational read of the head entry.
  - ready_i while empty has no effect.
- Latency: an entry pushed at edge N is visible on the outputs after edge N; there is no fall-through.
- Space check uses free = DEPTH - count before that cycle's pop; a simultaneous pop is not credited.
  - If pushes > free, the whole cycle's push set is dropped (never partial).
  - On a drop: overflow_o set (sticky until reset); drop_cnt_o += number of entries dropped, saturating.
  - A pop still occurs in that cycle if handshaken.
- Simultaneous push and pop: count_next = count + pushes - pop.
- Pointers wrap modulo DEPTH. Multi-entry pushes write consecutive slots mod DEPTH, including across the wrap.
- Order is preserved strictly: entries from an earlier cycle always precede later ones.
- Reset asserted mid-operation clears all state immediately; the buffer contents become don't-care and are never output.

Test Plan:
- Reset, then valids_i=2'b11, pcs={0x1004,0x1000}, ready_i=0 -> count_o=2 after one edge; valid_o=1, pc_o=0x1000. Raise ready_i -> next pc_o=0x1004, then valid_o=0.
- valids_i=2'b10, pc lane1=0x2002, compressed_i=2'b10 -> single entry: pc_o=0x2002, compressed_o=1, count_o=1.
- exception_i=1, interrupt_i=0, valids_i=2'b11, cause_i=2, tval_i=0xDEAD -> one entry: lane-0 PC, exception_o=1, cause_o=2, tval_o=0xDEAD, count_o=1.
- exception_i=1, interrupt_i=1, valids_i=0, trap_pc_i=0x3000, cause_i=7 -> iretired_o=0, interrupt_o=1, pc_o=0x3000.
- ready_i=0; push 2/cycle for 4 cycles (count_o=8), then 1 more cycle of 2 -> count_o stays 8, overflow_o=1, drop_cnt_o=2. Drain with ready_i=1 -> 8 entries in original order.
- DEPTH=8: fill to 7 with pointers at slot 6, then push 2 with a simultaneous pop -> dropped (free=1), drop_cnt_o increments by 2, count_o=6. Wrap-around order is verified on a later legal push.

Source files
------------

// File: rtl/mure_retire_fifo.sv
// Commit-port capture buffer: compacts the valid retire lanes of each cycle into a
// circular buffer and replays them one entry per cycle on a valid/ready interface.
module mure_retire_fifo #(
  parameter int NRET      = 2,
  parameter int DEPTH     = 8,
  parameter int XLEN      = 64,
  parameter int INST_LEN  = 32,
  parameter int CAUSE_LEN = 5,
  parameter int PRIV_LEN  = 2,
  localparam int CW       = $clog2(DEPTH + 1),
  localparam int PW       = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NRET-1:0]          valids_i,
  input  logic [NRET*XLEN-1:0]     pcs_i,
  input  logic [NRET*INST_LEN-1:0] insts_i,
  input  logic [NRET-1:0]          compressed_i,
  input  logic                     exception_i,
  input  logic                     interrupt_i,
  input  logic [CAUSE_LEN-1:0]     cause_i,
  input  logic [XLEN-1:0]          tval_i,
  input  logic [XLEN-1:0]          trap_pc_i,
  input  logic [PRIV_LEN-1:0]      priv_lvl_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     iretired_o,
  output logic                     exception_o,
  output logic                     interrupt_o,
  output logic [XLEN-1:0]          pc_o,
  output logic [INST_LEN-1:0]      inst_data_o,
  output logic                     compressed_o,
  output logic [CAUSE_LEN-1:0]     cause_o,
  output logic [XLEN-1:0]          tval_o,
  output logic [PRIV_LEN-1:0]      priv_o,
  output logic [CW-1:0]            count_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o
);

  typedef struct packed {
    logic                 iret;
    logic                 exc;
    logic                 intr;
    logic [XLEN-1:0]      pc;
    logic [INST_LEN-1:0]  inst;
    logic                 comp;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wrPtr;
  logic [PW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic [15:0]     r_dropCnt;

  entry_t          w_pushEnt [NRET];
  logic [CW-1:0]   w_pushCnt;
  logic [CW-1:0]   w_free;
  logic            w_fits;
  logic            w_pop;
  logic [16:0]     w_dropSum;
  entry_t          w_head;

  // Compact the push set into slots 0..w_pushCnt-1; a trap keeps only the lowest valid lane.
  always_comb begin
    w_pushCnt = '0;
    for (int j = 0; j < NRET; j++) begin
      w_pushEnt[j] = '0;
    end
    for (int k = 0; k < NRET; k++) begin
      if (valids_i[k] && (!exception_i || w_pushCnt == '0)) begin
        for (int j = 0; j < NRET; j++) begin
          if (w_pushCnt == CW'(j)) begin
            w_pushEnt[j].iret = 1'b1;
            w_pushEnt[j].pc   = pcs_i[k*XLEN +: XLEN];
            w_pushEnt[j].inst = insts_i[k*INST_LEN +: INST_LEN];
            w_pushEnt[j].comp = compressed_i[k];
          end
        end
        w_pushCnt = w_pushCnt + CW'(1);
      end
    end
    if (exception_i && w_pushCnt == '0) begin
      w_pushEnt[0].iret = 1'b0;
      w_pushEnt[0].pc   = trap_pc_i;
      w_pushCnt         = CW'(1);
    end
    if (exception_i) begin
      w_pushEnt[0].exc   = ~interrupt_i;
      w_pushEnt[0].intr  = interrupt_i;
      w_pushEnt[0].cause = cause_i;
      w_pushEnt[0].tval  = tval_i;
    end
    for (int j = 0; j < NRET; j++) begin
      w_pushEnt[j].priv = priv_lvl_i;
    end
  end

  // Free space ignores a same-cycle pop, so a full buffer drops even while draining.
  assign w_free    = CW'(DEPTH) - r_count;
  assign w_fits    = (w_pushCnt <= w_free);
  assign w_pop     = (r_count != '0) && ready_i;
  assign w_dropSum = {1'b0, r_dropCnt} + 17'(w_pushCnt);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_dropCnt  <= '0;
    end else begin
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      if (w_fits) begin
        r_wrPtr <= r_wrPtr + PW'(w_pushCnt);
      end else begin
        r_overflow <= 1'b1;
        r_dropCnt  <= w_dropSum[16] ? 16'hFFFF : w_dropSum[15:0];
      end
      r_count <= r_count + (w_fits ? w_pushCnt : CW'(0)) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NRET; i++) begin
      if (w_fits && CW'(i) < w_pushCnt) begin
        r_mem[r_wrPtr + PW'(i)] <= w_pushEnt[i];
      end
    end
  end

  assign w_head       = (r_count != '0) ? r_mem[r_rdPtr] : '0;
  assign valid_o      = (r_count != '0);
  assign iretired_o   = w_head.iret;
  assign exception_o  = w_head.exc;
  assign interrupt_o  = w_head.intr;
  assign pc_o         = w_head.pc;
  assign inst_data_o  = w_head.inst;
  assign compressed_o = w_head.comp;
  assign cause_o      = w_head.cause;
  assign tval_o       = w_head.tval;
  assign priv_o       = w_head.priv;
  assign count_o      = r_count;
  assign overflow_o   = r_overflow;
  assign drop_cnt_o   = r_dropCnt;

endmodule

// File: tb/tb_mure_retire_fifo.sv
// Scoreboard bench for mure_retire_fifo: expected entries are queued as commits are
// driven and compared against the head outputs every cycle.
module tb_mure_retire_fifo;

  localparam int NRET  = 2;
  localparam int DEPTH = 8;

  typedef struct {
    bit          iret;
    bit          exc;
    bit          intr;
    logic [63:0] pc;
    logic [31:0] inst;
    bit          comp;
    logic [4:0]  cause;
    logic [63:0] tval;
    logic [1:0]  priv;
  } ent_t;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [1:0]   valids_i = '0;
  logic [127:0] pcs_i = '0;
  logic [63:0]  insts_i = '0;
  logic [1:0]   compressed_i = '0;
  logic         exception_i = 1'b0;
  logic         interrupt_i = 1'b0;
  logic [4:0]   cause_i = '0;
  logic [63:0]  tval_i = '0;
  logic [63:0]  trap_pc_i = '0;
  logic [1:0]   priv_lvl_i = '0;
  logic         ready_i = 1'b0;
  logic         valid_o, iretired_o, exception_o, interrupt_o, compressed_o, overflow_o;
  logic [63:0]  pc_o, tval_o;
  logic [31:0]  inst_data_o;
  logic [4:0]   cause_o;
  logic [1:0]   priv_o;
  logic [3:0]   count_o;
  logic [15:0]  drop_cnt_o;

  ent_t sb[$];
  bit          modelOvf = 1'b0;
  int          modelDrop = 0;
  int          total = 0;
  int          bad = 0;

  mure_retire_fifo #(.NRET(NRET), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valids_i(valids_i), .pcs_i(pcs_i), .insts_i(insts_i),
    .compressed_i(compressed_i), .exception_i(exception_i), .interrupt_i(interrupt_i),
    .cause_i(cause_i), .tval_i(tval_i), .trap_pc_i(trap_pc_i), .priv_lvl_i(priv_lvl_i),
    .valid_o(valid_o), .ready_i(ready_i), .iretired_o(iretired_o), .exception_o(exception_o),
    .interrupt_o(interrupt_o), .pc_o(pc_o), .inst_data_o(inst_data_o),
    .compressed_o(compressed_o), .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o),
    .count_o(count_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1,
                               input logic [1:0] comp, input logic exc, input logic intr,
                               input logic [4:0] cause, input logic [63:0] tval,
                               input logic [63:0] trapPc, input logic rdy);
    valids_i     = v;
    pcs_i        = {p1, p0};
    insts_i      = {~p1[31:0], ~p0[31:0]};
    compressed_i = comp;
    exception_i  = exc;
    interrupt_i  = intr;
    cause_i      = cause;
    tval_i       = tval;
    trap_pc_i    = trapPc;
    ready_i      = rdy;
  endtask

  task automatic checkAll();
    checkOutput("count", 64'(count_o), 64'(sb.size()));
    checkOutput("valid", 64'(valid_o), 64'(sb.size() != 0));
    checkOutput("overflow", 64'(overflow_o), 64'(modelOvf));
    checkOutput("dropCnt", 64'(drop_cnt_o), 64'(modelDrop));
    if (sb.size() != 0) begin
      checkOutput("pc", pc_o, sb[0].pc);
      checkOutput("inst", 64'(inst_data_o), 64'(sb[0].inst));
      checkOutput("iretired", 64'(iretired_o), 64'(sb[0].iret));
      checkOutput("exception", 64'(exception_o), 64'(sb[0].exc));
      checkOutput("interrupt", 64'(interrupt_o), 64'(sb[0].intr));
      checkOutput("compressed", 64'(compressed_o), 64'(sb[0].comp));
      checkOutput("cause", 64'(cause_o), 64'(sb[0].cause));
      checkOutput("tval", tval_o, sb[0].tval);
      checkOutput("priv", 64'(priv_o), 64'(sb[0].priv));
    end else begin
      checkOutput("emptyPc", pc_o, 64'h0);
      checkOutput("emptyCause", 64'(cause_o), 64'h0);
      checkOutput("emptyIret", 64'(iretired_o), 64'h0);
    end
  endtask

  // Build the expected push set from the driven inputs, advance one edge, update the model.
  task automatic tick();
    ent_t pend[$];
    ent_t e;
    int   freeSlots;
    bit   popNow;
    for (int k = 0; k < NRET; k++) begin
      if (valids_i[k] && (!exception_i || pend.size() == 0)) begin
        e = '{iret: 1'b1, exc: 1'b0, intr: 1'b0, pc: pcs_i[k*64 +: 64],
              inst: insts_i[k*32 +: 32], comp: compressed_i[k], cause: 5'd0,
              tval: 64'd0, priv: priv_lvl_i};
        pend.push_back(e);
      end
    end
    if (exception_i && pend.size() == 0) begin
      e = '{iret: 1'b0, exc: 1'b0, intr: 1'b0, pc: trap_pc_i, inst: 32'd0, comp: 1'b0,
            cause: 5'd0, tval: 64'd0, priv: priv_lvl_i};
      pend.push_back(e);
    end
    if (exception_i) begin
      pend[0].exc   = !interrupt_i;
      pend[0].intr  = interrupt_i;
      pend[0].cause = cause_i;
      pend[0].tval  = tval_i;
    end
    freeSlots = DEPTH - sb.size();
    popNow = (sb.size() != 0) && ready_i;
    @(posedge clk_i);
    if (popNow) void'(sb.pop_front());
    if (pend.size() > freeSlots) begin
      modelOvf  = 1'b1;
      modelDrop = (modelDrop + pend.size() > 16'hFFFF) ? 16'hFFFF : modelDrop + pend.size();
    end else begin
      foreach (pend[i]) sb.push_back(pend[i]);
    end
    #1;
    checkAll();
  endtask

  task automatic idle(input logic rdy, input int n);
    applyStimulus(2'b00, 64'd0, 64'd0, 2'b00, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, rdy);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    checkAll();
    @(negedge clk_i);
    rst_i = 1'b0;

    // Two lanes, then drain one per cycle
    priv_lvl_i = 2'd3;
    applyStimulus(2'b11, 64'h1000, 64'h1004, 2'b00, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
    tick();
    checkOutput("t1Count", 64'(count_o), 64'd2);
    checkOutput("t1Pc", pc_o, 64'h1000);
    idle(1'b1, 1);
    checkOutput("t1Pc2", pc_o, 64'h1004);
    idle(1'b1, 1);
    checkOutput("t1Empty", 64'(valid_o), 64'd0);

    // Lane gap: only lane 1 valid
    priv_lvl_i = 2'd1;
    applyStimulus(2'b10, 64'h1111, 64'h2002, 2'b10, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
    tick();
    checkOutput("t2Pc", pc_o, 64'h2002);
    checkOutput("t2Comp", 64'(compressed_o), 64'd1);
    idle(1'b1, 1);

    // Exception kills lane 1
    applyStimulus(2'b11, 64'h4000, 64'h4004, 2'b00, 1'b1, 1'b0, 5'd2, 64'hDEAD, 64'd0, 1'b0);
    tick();
    checkOutput("t3Count", 64'(count_o), 64'd1);
    checkOutput("t3Exc", 64'(exception_o), 64'd1);
    checkOutput("t3Tval", tval_o, 64'hDEAD);
    idle(1'b1, 1);

    // Interrupt with no retirement
    applyStimulus(2'b00, 64'h0, 64'h0, 2'b00, 1'b1, 1'b1, 5'd7, 64'h55, 64'h3000, 1'b0);
    tick();
    checkOutput("t4Iret", 64'(iretired_o), 64'd0);
    checkOutput("t4Intr", 64'(interrupt_o), 64'd1);
    checkOutput("t4Pc", pc_o, 64'h3000);
    idle(1'b1, 1);

    // Fill to full, then one dropped cycle, then drain
    for (int c = 0; c < 5; c++) begin
      applyStimulus(2'b11, 64'h5000 + 64'(c*8), 64'h5004 + 64'(c*8), 2'b01, 1'b0, 1'b0,
                    5'd0, 64'd0, 64'd0, 1'b0);
      tick();
    end
    checkOutput("t5Count", 64'(count_o), 64'd8);
    checkOutput("t5Ovf", 64'(overflow_o), 64'd1);
    checkOutput("t5Drop", 64'(drop_cnt_o), 64'd2);
    idle(1'b1, 8);

    // Move write pointer to slot 7, fill 7 across the wrap, then drop with a simultaneous pop
    applyStimulus(2'b11, 64'h6000, 64'h6004, 2'b00, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
    tick();
    idle(1'b1, 2);
    for (int c = 0; c < 4; c++) begin
      applyStimulus((c == 3) ? 2'b01 : 2'b11, 64'h7000 + 64'(c*8), 64'h7004 + 64'(c*8),
                    2'b10, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
      tick();
    end
    checkOutput("t6Fill", 64'(count_o), 64'd7);
    applyStimulus(2'b11, 64'h8000, 64'h8004, 2'b00, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b1);
    tick();
    checkOutput("t6Count", 64'(count_o), 64'd6);
    checkOutput("t6Drop", 64'(drop_cnt_o), 64'd4);
    applyStimulus(2'b11, 64'h9000, 64'h9004, 2'b11, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
    tick();
    idle(1'b1, 9);

    // Asynchronous reset mid-operation
    applyStimulus(2'b11, 64'hA000, 64'hA004, 2'b00, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
    tick();
    #2;
    rst_i = 1'b1;
    #1;
    sb.delete();
    modelOvf  = 1'b0;
    modelDrop = 0;
    checkAll();
    @(negedge clk_i);
    rst_i = 1'b0;

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      priv_lvl_i = 2'($urandom_range(0, 3));
      applyStimulus(2'($urandom_range(0, 3)), {32'h0, $urandom}, {32'h1, $urandom},
                    2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    {$urandom, $urandom}, {32'h2, $urandom}, ($urandom_range(0, 2) != 0));
      tick();
    end
    idle(1'b1, DEPTH + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
